// File: rtl/flit_char_pkg.sv
// Shared types and defaults for the flit energy-characterization blocks.
package flit_char_pkg;

  localparam int PAYLOAD_DEF = 20;
  localparam int GAP_DEF     = 7;
  localparam int CNT_W_DEF   = 16;

  // Record fields are stored at this fixed width; blocks use the low CNT_W
  // bits, so CNT_W may be at most REC_W.
  localparam int REC_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [REC_W-1:0] flits;
    logic [REC_W-1:0] toggles;
    logic             len_err;
    logic             gap_err;
  } stat_rec_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count of an N-bit word.
module popcount #(
  parameter int N = 17
) (
  input  logic [N-1:0]             data,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  // Sum of set bits, unrolled at elaboration.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/flit_sink_monitor.sv
// Frames a valid-qualified flit stream into packets, counts flits and bit
// toggles per packet, checks length and inter-packet gap, and offers one
// statistics record per packet over a valid/ready handshake.
module flit_sink_monitor
  import flit_char_pkg::*;
#(
  parameter int N       = 17,
  parameter int PAYLOAD = PAYLOAD_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic [CNT_W-1:0] stat_flits,
  output logic [CNT_W-1:0] stat_toggles,
  output logic             stat_len_err,
  output logic             stat_gap_err,
  output logic             stat_overrun,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int PW = $clog2(N + 1);
  localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);

  rx_state_t        state;
  logic [CNT_W-1:0] flit_cnt;
  logic [CNT_W-1:0] tog_cnt;
  logic [N-1:0]     prev_data;
  logic [GW-1:0]    gap_cnt;
  logic             first_pkt;
  logic             gap_short;
  stat_rec_t        rec;
  logic [PW-1:0]    pop;
  logic             pkt_start;
  logic             pkt_close;
  logic             rec_free;

  popcount #(.N(N)) u_popcount (
    .data  (in_data ^ prev_data),
    .count (pop)
  );

  // Saturating add of a small increment into a working counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Packet framing events and whether the record register can take a new record.
  always_comb begin
    pkt_start = (state == IDLE) && in_valid;
    pkt_close = (state == RECV) && !in_valid;
    rec_free  = !stat_valid || stat_ready;
  end

  // Receive FSM, working counters, gap tracking and output record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flit_cnt     <= '0;
      tog_cnt      <= '0;
      prev_data    <= '0;
      gap_cnt      <= '0;
      first_pkt    <= 1'b1;
      gap_short    <= 1'b0;
      rec          <= '0;
      stat_valid   <= 1'b0;
      stat_overrun <= 1'b0;
      pkt_count    <= '0;
    end else begin
      if (in_valid) begin
        prev_data <= in_data;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= RECV;
            flit_cnt  <= sat_add('0, PW'(1));
            tog_cnt   <= sat_add('0, pop);
            gap_short <= first_pkt ? 1'b0 : (gap_cnt < GW'(GAP));
            first_pkt <= 1'b0;
            gap_cnt   <= '0;
          end else if (gap_cnt < GW'(GAP)) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        RECV: begin
          if (in_valid) begin
            flit_cnt <= sat_add(flit_cnt, PW'(1));
            tog_cnt  <= sat_add(tog_cnt, pop);
          end else begin
            // The closing cycle is itself the first idle cycle of the gap.
            state   <= IDLE;
            gap_cnt <= (GAP > 0) ? GW'(1) : '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (pkt_close) begin
        pkt_count <= pkt_count + CNT_W'(1);
        if (rec_free) begin
          rec.flits   <= REC_W'(flit_cnt);
          rec.toggles <= REC_W'(tog_cnt);
          rec.len_err <= (REC_W'(flit_cnt) != REC_W'(PAYLOAD));
          rec.gap_err <= gap_short;
          stat_valid  <= 1'b1;
        end else begin
          stat_overrun <= 1'b1;
        end
      end else if (stat_valid && stat_ready) begin
        stat_valid <= 1'b0;
      end
    end
  end

  assign stat_flits   = rec.flits[CNT_W-1:0];
  assign stat_toggles = rec.toggles[CNT_W-1:0];
  assign stat_len_err = rec.len_err;
  assign stat_gap_err = rec.gap_err;

  // Upper record bits are always zero when CNT_W is below the record width.
  if (CNT_W < REC_W) begin : g_rec_pad
    logic unused_rec_hi;
    assign unused_rec_hi = ^{rec.flits[REC_W-1:CNT_W], rec.toggles[REC_W-1:CNT_W]};
  end

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed scoreboard bench for flit_sink_monitor, plus a narrow-counter
// instance for toggle saturation.
module tb_flit_sink_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_data;
  logic        stat_ready;
  logic        stat_valid;
  logic [15:0] stat_flits;
  logic [15:0] stat_toggles;
  logic        stat_len_err;
  logic        stat_gap_err;
  logic        stat_overrun;
  logic [15:0] pkt_count;

  logic        s_valid;
  logic [7:0]  s_flits;
  logic [7:0]  s_toggles;
  logic        s_len_err;
  logic        s_gap_err;
  logic        s_overrun;
  logic [7:0]  s_pkt_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int flits;
    int toggles;
    bit len_err;
    bit gap_err;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] tb_prev;

  flit_sink_monitor #(.N(17), .PAYLOAD(20), .GAP(7), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .stat_valid   (stat_valid),
    .stat_ready   (stat_ready),
    .stat_flits   (stat_flits),
    .stat_toggles (stat_toggles),
    .stat_len_err (stat_len_err),
    .stat_gap_err (stat_gap_err),
    .stat_overrun (stat_overrun),
    .pkt_count    (pkt_count)
  );

  flit_sink_monitor #(.N(17), .PAYLOAD(20), .GAP(7), .CNT_W(8)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .stat_valid   (s_valid),
    .stat_ready   (1'b0),
    .stat_flits   (s_flits),
    .stat_toggles (s_toggles),
    .stat_len_err (s_len_err),
    .stat_gap_err (s_gap_err),
    .stat_overrun (s_overrun),
    .pkt_count    (s_pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare the record being handed over against the scoreboard head.
  task automatic pop_record();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_record", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rec_flits",   32'(stat_flits),   32'(e.flits));
      chk("rec_toggles", 32'(stat_toggles), 32'(e.toggles));
      chk("rec_len_err", 32'(stat_len_err), 32'(e.len_err));
      chk("rec_gap_err", 32'(stat_gap_err), 32'(e.gap_err));
    end
  endtask

  // Drive one cycle; inputs change 1 time unit after an edge.
  task automatic cycle(input logic v, input logic [16:0] d);
    in_valid = v;
    in_data  = d;
    if (stat_valid === 1'b1 && stat_ready === 1'b1) pop_record();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 17'($urandom));
  endtask

  task automatic send_pkt(input int n, input logic [16:0] a, input logic [16:0] b,
                          input bit gap_exp, input bit push);
    exp_t        e;
    logic [16:0] d;
    e.flits   = 0;
    e.toggles = 0;
    for (int i = 0; i < n; i++) begin
      d = (i % 2 == 0) ? a : b;
      e.toggles += $countones(d ^ tb_prev);
      tb_prev = d;
      e.flits++;
      cycle(1'b1, d);
    end
    e.len_err = (e.flits != 20);
    e.gap_err = gap_exp;
    if (push) sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_prev = '0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    stat_ready = 1'b0;
    tb_prev    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_valid",   32'(stat_valid),   32'd0);
    chk("rst_flits",   32'(stat_flits),   32'd0);
    chk("rst_toggles", 32'(stat_toggles), 32'd0);
    chk("rst_len_err", 32'(stat_len_err), 32'd0);
    chk("rst_gap_err", 32'(stat_gap_err), 32'd0);
    chk("rst_overrun", 32'(stat_overrun), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_count),    32'd0);
    rst = 1'b0;

    // Basic packet and close latency
    idle(2);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b0, 1'b1);
    chk("basic_valid_at_last_flit", 32'(stat_valid), 32'd0);
    idle(1);
    chk("basic_valid_after_close", 32'(stat_valid), 32'd1);
    chk("basic_toggles_340",       32'(stat_toggles), 32'd340);
    chk("basic_pkt_count",         32'(pkt_count), 32'd1);
    stat_ready = 1'b1;
    idle(1);
    chk("basic_valid_after_accept", 32'(stat_valid), 32'd0);

    // Gap checks: 8 idle then packet, 3 idle then packet, 7 idle then packet
    idle(7);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b0, 1'b1);
    idle(3);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b1, 1'b1);
    idle(7);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b0, 1'b1);
    idle(8);

    // Length error: 5 flits of 0x00001 from prev_data = 0
    chk("len_prev_zero", 32'(tb_prev), 32'd0);
    send_pkt(5, 17'h00001, 17'h00001, 1'b0, 1'b1);
    idle(2);
    chk("len_pkt_count", 32'(pkt_count), 32'd5);

    // Backpressure across two packets
    stat_ready = 1'b0;
    do_reset();
    idle(2);
    send_pkt(20, 17'h0F0F0, 17'h10F0F, 1'b0, 1'b1);
    idle(8);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b0, 1'b0);
    idle(2);
    chk("bp_valid_held",   32'(stat_valid),   32'd1);
    chk("bp_flits_held",   32'(stat_flits),   32'(sb[0].flits));
    chk("bp_toggles_held", 32'(stat_toggles), 32'(sb[0].toggles));
    chk("bp_overrun",      32'(stat_overrun), 32'd1);
    chk("bp_pkt_count",    32'(pkt_count),    32'd2);
    stat_ready = 1'b1;
    idle(1);
    stat_ready = 1'b0;
    chk("bp_valid_dropped", 32'(stat_valid),   32'd0);
    chk("bp_overrun_stuck", 32'(stat_overrun), 32'd1);

    // Reset in the middle of a packet
    stat_ready = 1'b1;
    idle(8);
    send_pkt(10, 17'h1FFFF, 17'h00000, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 17'h1FFFF);
    chk("mid_rst_valid",   32'(stat_valid),   32'd0);
    chk("mid_rst_flits",   32'(stat_flits),   32'd0);
    chk("mid_rst_toggles", 32'(stat_toggles), 32'd0);
    chk("mid_rst_overrun", 32'(stat_overrun), 32'd0);
    chk("mid_rst_pkt_cnt", 32'(pkt_count),    32'd0);
    rst = 1'b0;
    tb_prev = '0;
    idle(3);
    chk("mid_rst_no_record", 32'(stat_valid), 32'd0);
    send_pkt(20, 17'h1FFFF, 17'h00000, 1'b0, 1'b1);
    idle(1);

    // Saturation on the 8-bit counter instance
    chk("sat_valid",   32'(s_valid),   32'd1);
    chk("sat_flits",   32'(s_flits),   32'd20);
    chk("sat_toggles", 32'(s_toggles), 32'd255);
    chk("sat_len_err", 32'(s_len_err), 32'd0);

    idle(2);
    chk("final_pkt_count", 32'(pkt_count), 32'd1);
    chk("sb_drained",      32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
